// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared definitions for the LDM/STM block-transfer sequencer:
// the FSM state set, the default address step and the {pre,up} mode encoding.
package ldm_stm_sequencer_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_XFER,
    ST_WBACK,
    ST_FIN
  } state_t;

  // Encoded as {pre, up}
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } addr_mode_t;

endpackage

// File: rtl/ldm_stm_sequencer_lowest_bit.sv
// Combinational lowest-set-bit encoder over a 16-bit register mask.
// Picks the next register to transfer. valid is low when the mask is empty.
module ldm_lowest_bit (
  input  logic [15:0] mask,
  output logic [3:0]  idx,
  output logic        valid
);

  // Scan from the top so that the lowest set bit is the last one written
  always_comb begin
    idx   = '0;
    valid = |mask;
    for (int i = 15; i >= 0; i--) begin
      if (mask[i]) idx = 4'(i);
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM block-transfer sequencer.
// Walks a 16-bit register list lowest index first, one memory beat per mem_ack,
// and optionally writes the final address back to the base register.
// Handshake and control outputs are registered. Store data, and load/writeback
// register-file writes, are steered combinationally because they must line up
// with the register-file read data and the mem_ack cycle.
module ldm_stm_sequencer #(
  parameter int unsigned WORD_BYTES = ldm_stm_sequencer_pkg::WORD_BYTES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        up,
  input  logic        pre,
  input  logic        wback,
  input  logic [3:0]  base_reg,
  input  logic [31:0] base_addr,
  input  logic [15:0] reg_list,
  output logic        busy,
  output logic        done,
  output logic [3:0]  rf_read_addr,
  input  logic [31:0] rf_read_data,
  output logic [3:0]  rf_write_addr,
  output logic [31:0] rf_write_data,
  output logic        rf_reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  import ldm_stm_sequencer_pkg::*;

  state_t      state;
  logic        is_load_q;
  logic        up_q;
  logic        pre_q;
  logic        wback_q;
  logic [3:0]  base_reg_q;
  logic [31:0] base_q;
  // Full request list in SETUP; afterwards only the registers not yet issued
  logic [15:0] mask_q;
  logic [3:0]  cur_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] addr_q;
  logic        wb_en_q;
  logic [31:0] wb_data_q;
  logic        busy_q;
  logic        done_q;

  logic [3:0]  low_idx;
  logic        low_valid;
  logic [4:0]  pop_cnt;
  logic [31:0] span;
  logic [31:0] start_addr;
  logic        store_beat;
  logic        load_ack;
  logic        wb_cycle;

  ldm_lowest_bit u_lowest_bit (
    .mask  (mask_q),
    .idx   (low_idx),
    .valid (low_valid)
  );

  // Register count, block span and first transfer address from the latched request
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < 16; i++) begin
      pop_cnt = pop_cnt + {4'b0, mask_q[i]};
    end
    span = 32'(WORD_BYTES) * {27'b0, pop_cnt};
    case (addr_mode_t'({pre_q, up_q}))
      MODE_IA: start_addr = base_q;
      MODE_IB: start_addr = base_q + 32'(WORD_BYTES);
      MODE_DA: start_addr = base_q - span + 32'(WORD_BYTES);
      default: start_addr = base_q - span;
    endcase
  end

  // Sequencer FSM with registered handshake, address and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_load_q  <= 1'b0;
      up_q       <= 1'b0;
      pre_q      <= 1'b0;
      wback_q    <= 1'b0;
      base_reg_q <= '0;
      base_q     <= '0;
      mask_q     <= '0;
      cur_q      <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
      wb_en_q    <= 1'b0;
      wb_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_load_q  <= is_load;
            up_q       <= up;
            pre_q      <= pre;
            wback_q    <= wback;
            base_reg_q <= base_reg;
            base_q     <= base_addr;
            mask_q     <= reg_list;
            busy_q     <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          // A load that includes the base register keeps the loaded value
          wb_en_q   <= wback_q && !(is_load_q && mask_q[base_reg_q]);
          wb_data_q <= up_q ? (base_q + span) : (base_q - span);
          if (!low_valid) begin
            state  <= ST_FIN;
            done_q <= 1'b1;
          end else begin
            state     <= ST_XFER;
            mem_req_q <= 1'b1;
            mem_we_q  <= !is_load_q;
            addr_q    <= start_addr;
            cur_q     <= low_idx;
            mask_q    <= mask_q & ~(16'h0001 << low_idx);
          end
        end
        ST_XFER: begin
          if (mem_ack) begin
            if (low_valid) begin
              cur_q  <= low_idx;
              mask_q <= mask_q & ~(16'h0001 << low_idx);
              addr_q <= addr_q + 32'(WORD_BYTES);
            end else begin
              mem_req_q <= 1'b0;
              mem_we_q  <= 1'b0;
              addr_q    <= '0;
              cur_q     <= '0;
              if (wb_en_q) begin
                state <= ST_WBACK;
              end else begin
                state  <= ST_FIN;
                done_q <= 1'b1;
              end
            end
          end
        end
        ST_WBACK: begin
          state  <= ST_FIN;
          done_q <= 1'b1;
        end
        ST_FIN: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Steer store data, load data and the writeback value onto the external buses
  always_comb begin
    store_beat    = mem_req_q & mem_we_q;
    load_ack      = mem_req_q & ~mem_we_q & mem_ack;
    wb_cycle      = (state == ST_WBACK);
    busy          = busy_q;
    done          = done_q;
    mem_req       = mem_req_q;
    mem_we        = mem_we_q;
    mem_addr      = addr_q;
    rf_read_addr  = store_beat ? cur_q : 4'd0;
    mem_wdata     = store_beat ? rf_read_data : 32'd0;
    rf_reg_write  = load_ack | wb_cycle;
    rf_write_addr = wb_cycle ? base_reg_q : (load_ack ? cur_q : 4'd0);
    rf_write_data = wb_cycle ? wb_data_q : (load_ack ? mem_rdata : 32'd0);
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard testbench for ldm_stm_sequencer.
// Directed requests push their hand-computed memory beats, register writes and
// done latency into a queue; a negedge monitor pops and compares each one.
module tb_ldm_stm_sequencer;

  localparam int EV_MEM  = 0;
  localparam int EV_RF   = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        up = 1'b0;
  logic        pre = 1'b0;
  logic        wback = 1'b0;
  logic [3:0]  base_reg = '0;
  logic [31:0] base_addr = '0;
  logic [15:0] reg_list = '0;
  logic        busy;
  logic        done;
  logic [3:0]  rf_read_addr;
  logic [31:0] rf_read_data;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        rf_reg_write;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  start_cyc = 0;
  int  done_count = 0;
  int  done_base = 0;
  int  ack_wait = 0;
  int  wait_cnt = 0;
  ev_t exp_q[$];

  logic        prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;

  ldm_stm_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .is_load       (is_load),
    .up            (up),
    .pre           (pre),
    .wback         (wback),
    .base_reg      (base_reg),
    .base_addr     (base_addr),
    .reg_list      (reg_list),
    .busy          (busy),
    .done          (done),
    .rf_read_addr  (rf_read_addr),
    .rf_read_data  (rf_read_data),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_reg_write  (rf_reg_write),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
  );

  always #5 clk = ~clk;

  // Register file returns a recognisable value per index; memory returns one per address
  assign rf_read_data = 32'hC0DE_0000 + {28'b0, rf_read_addr};
  assign mem_ack      = mem_req && (wait_cnt >= ack_wait);
  assign mem_rdata    = mem_ack ? (32'h5A5A_0000 + mem_addr) : 32'hDEAD_BEEF;

  // Free-running cycle counter used for done latency
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: holds off ack for ack_wait cycles of each beat
  always @(posedge clk) begin
    if (rst) wait_cnt <= 0;
    else if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic pushExpected(input int kind, input logic we, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic compareEvent(input int kind, input logic we, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_event actual kind=%0d we=%0b addr=%h data=%h required none", kind, we, addr, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.we !== we || e.addr !== addr || e.data !== data) begin
        failures++;
        $display("[TB] FAIL event actual kind=%0d we=%0b addr=%h data=%h required kind=%0d we=%0b addr=%h data=%h",
                 kind, we, addr, data, e.kind, e.we, e.addr, e.data);
      end
    end
  endtask

  // Monitor: compares every memory beat, register write and done pulse against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_pending && mem_req) checkOutput("addr_stable", mem_addr, prev_addr);
      if (mem_req && mem_ack) compareEvent(EV_MEM, mem_we, mem_addr, mem_wdata);
      if (rf_reg_write) compareEvent(EV_RF, 1'b0, {28'b0, rf_write_addr}, rf_write_data);
      if (done) begin
        compareEvent(EV_DONE, 1'b0, 32'd0, 32'(cyc - start_cyc + 1));
        checkOutput("busy_with_done", {31'b0, busy}, 32'd1);
        done_count++;
      end
      prev_pending = mem_req && !mem_ack;
      prev_addr    = mem_addr;
    end else begin
      prev_pending = 1'b0;
    end
  end

  task automatic applyStimulus(input logic ld, input logic u, input logic p, input logic wb,
                               input logic [3:0] breg, input logic [31:0] base, input logic [15:0] list);
    @(posedge clk);
    #1;
    is_load   = ld;
    up        = u;
    pre       = p;
    wback     = wb;
    base_reg  = breg;
    base_addr = base;
    reg_list  = list;
    done_base = done_count;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic waitDone(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_count > done_base && !busy) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_completed"}, {31'b0, ok}, 32'd1);
    checkOutput({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_busy"}, {31'b0, busy}, 32'd0);
    checkOutput({name, "_done"}, {31'b0, done}, 32'd0);
    checkOutput({name, "_mem_req_we"}, {30'b0, mem_req, mem_we}, 32'd0);
    checkOutput({name, "_rf_reg_write"}, {31'b0, rf_reg_write}, 32'd0);
    checkOutput({name, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({name, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({name, "_rf_addrs"}, {24'b0, rf_read_addr, rf_write_addr}, 32'd0);
    checkOutput({name, "_rf_write_data"}, rf_write_data, 32'd0);
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;

    #12;
    checkIdleOutputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // STM IA, R1 R2 R4 from 0x1000
    pushExpected(EV_MEM, 1'b1, 32'h0000_1000, 32'hC0DE_0001);
    pushExpected(EV_MEM, 1'b1, 32'h0000_1004, 32'hC0DE_0002);
    pushExpected(EV_MEM, 1'b1, 32'h0000_1008, 32'hC0DE_0004);
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'h0000_1000, 16'h0016);
    waitDone("stm_ia");

    // LDM DB with writeback to R13
    pushExpected(EV_MEM, 1'b0, 32'h0000_1FF4, 32'd0);
    pushExpected(EV_RF, 1'b0, 32'd4, 32'h5A5A_1FF4);
    pushExpected(EV_MEM, 1'b0, 32'h0000_1FF8, 32'd0);
    pushExpected(EV_RF, 1'b0, 32'd5, 32'h5A5A_1FF8);
    pushExpected(EV_MEM, 1'b0, 32'h0000_1FFC, 32'd0);
    pushExpected(EV_RF, 1'b0, 32'd14, 32'h5A5A_1FFC);
    pushExpected(EV_RF, 1'b0, 32'd13, 32'h0000_1FF4);
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd6);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 32'h0000_2000, 16'h4030);
    waitDone("ldm_db_wb");

    // LDM IA with base in list: loaded value wins, no writeback
    pushExpected(EV_MEM, 1'b0, 32'h0000_4000, 32'd0);
    pushExpected(EV_RF, 1'b0, 32'd1, 32'h5A5A_4000);
    pushExpected(EV_MEM, 1'b0, 32'h0000_4004, 32'd0);
    pushExpected(EV_RF, 1'b0, 32'd2, 32'h5A5A_4004);
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 32'h0000_4000, 16'h0006);
    waitDone("ldm_base_in_list");

    // Empty list with wback set: no traffic at all
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd7, 32'h0000_8000, 16'h0000);
    waitDone("empty_list");

    // STM DA with writeback
    pushExpected(EV_MEM, 1'b1, 32'h0000_4FFC, 32'hC0DE_0000);
    pushExpected(EV_MEM, 1'b1, 32'h0000_5000, 32'hC0DE_0001);
    pushExpected(EV_RF, 1'b0, 32'd3, 32'h0000_4FF8);
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 32'h0000_5000, 16'h0003);
    waitDone("stm_da_wb");

    // STM IA wrapping past 2^32
    pushExpected(EV_MEM, 1'b1, 32'hFFFF_FFFC, 32'hC0DE_0000);
    pushExpected(EV_MEM, 1'b1, 32'h0000_0000, 32'hC0DE_0001);
    pushExpected(EV_RF, 1'b0, 32'd5, 32'h0000_0004);
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'd5, 32'hFFFF_FFFC, 16'h0003);
    waitDone("stm_wrap");

    // LDM of R15 alone, writeback to R0
    pushExpected(EV_MEM, 1'b0, 32'h0000_7000, 32'd0);
    pushExpected(EV_RF, 1'b0, 32'd15, 32'h5A5A_7000);
    pushExpected(EV_RF, 1'b0, 32'd0, 32'h0000_7004);
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd4);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 32'h0000_7000, 16'h8000);
    waitDone("ldm_r15");

    // STM IB with 3-cycle ack delay and a stray start mid-transfer
    ack_wait = 3;
    pushExpected(EV_MEM, 1'b1, 32'h0000_3004, 32'hC0DE_0000);
    pushExpected(EV_MEM, 1'b1, 32'h0000_3008, 32'hC0DE_000F);
    pushExpected(EV_DONE, 1'b0, 32'd0, 32'd10);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0000_3000, 16'h8001);
    repeat (3) @(posedge clk);
    #1;
    start     = 1'b1;
    is_load   = 1'b1;
    wback     = 1'b1;
    base_addr = 32'h0000_BAD0;
    reg_list  = 16'hFFFF;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone("delayed_ack");

    // Reset during the second beat of a 4-register LDM
    ack_wait = 2;
    pushExpected(EV_MEM, 1'b0, 32'h0000_6000, 32'd0);
    pushExpected(EV_RF, 1'b0, 32'd4, 32'h5A5A_6000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 32'h0000_6000, 16'h00F0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (mem_req && mem_addr == 32'h0000_6004) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("abort_second_beat_reached", {31'b0, found}, 32'd1);
    rst = 1'b1;
    #1;
    checkIdleOutputs("abort");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done_count), 32'(done_base));
    checkOutput("abort_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("abort_idle_busy", {31'b0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
